mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameters SHALL be exactly:
  BASE_ADDR, 1024, byte address of data-memory word 0
  DEPTH_WORDS, 64, number of 32-bit words in data memory
  WAIT_CYCLES, 2, extra wait cycles per memory access (0..15)
REQ-002 One clock; reset is synchronous and active-high, ports clk and rst.
REQ-003 Ports SHALL be exactly:
  clk  in  1  clock, rising edge
  rst  in  1  synchronous active-high reset
  req_valid  in  1  pipeline load/store request present
  req_we  in  1  1=store, 0=load
  req_addr  in  32  byte address
  req_wdata  in  32  store data
  req_ready  out  1  controller can accept a request
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  load data (0 for store/error)
  resp_err  out  1  request rejected (range/alignment)
  freeze  out  1  stall pipeline stages upstream of MEM
  mem_read  out  1  memory read strobe
  mem_write  out  1  memory write strobe, one cycle per store
  mem_address  out  32  byte address to memory
  mem_data  out  32  write data to memory
  mem_res  in  32  combinational read data from memory

Function
REQ-004 FSM states SHALL be IDLE, WAIT, RESP; reset state IDLE.
REQ-005 req_ready SHALL be 1 only in IDLE; acceptance = req_valid & req_ready at a rising edge.
REQ-006 Request valid iff BASE_ADDR <= req_addr < BASE_ADDR+4*DEPTH_WORDS and req_addr[1:0]==0; comparisons unsigned 32-bit.
REQ-007 Invalid accepted request: IDLE->RESP; no mem_read/mem_write; resp_err=1, resp_rdata=0 in RESP.
REQ-008 Valid accepted request: latch we/addr/wdata; load wait counter with WAIT_CYCLES; IDLE->WAIT.
REQ-009 WAIT: counter decrements each cycle; WAIT->RESP at the edge where counter==0; WAIT lasts WAIT_CYCLES+1 cycles.
REQ-010 In WAIT, mem_address/mem_data SHALL be the latched values, stable for the whole access.
REQ-011 Load: mem_read=1 throughout WAIT; mem_res captured into resp_rdata register at WAIT->RESP edge.
REQ-012 Store: mem_write=1 only in the final WAIT cycle (counter==0) and gated by ~rst; exactly one write per store.
REQ-013 RESP: resp_valid=1 for exactly one cycle; resp_err and resp_rdata valid in that cycle only; RESP->IDLE unconditionally.
REQ-014 Outside WAIT: mem_read=0, mem_write=0, mem_address=0, mem_data=0.
REQ-015 freeze = (IDLE & req_valid) | WAIT; freeze=0 in RESP so the pipeline advances with resp data.
REQ-016 Latency: resp_valid high in the cycle after WAIT_CYCLES+2 rising edges counted from the acceptance edge, inclusive of it (error path: after 1 edge).
REQ-017 req_* changes after acceptance SHALL NOT affect the in-flight access.
REQ-018 resp_rdata SHALL be 0 whenever resp_valid=0.

Reset
REQ-019 rst=1 at an edge SHALL force IDLE, clear counter, latches and resp registers; all outputs 0 except req_ready=1.
REQ-020 rst asserted during WAIT SHALL abort the access with no mem_write in that cycle and no resp_valid.

Structure
REQ-021 Package mem_ctrl_pkg SHALL hold the state enum, default BASE_ADDR/DEPTH_WORDS/WAIT_CYCLES constants.
REQ-022 Range/alignment check SHALL be sub-module mem_addr_check (addr in, ok out, combinational).
REQ-023 Bench SHALL pair the block with the 64-word data memory responder (base 1024).

Verification
REQ-024 Store addr=1028 data=0xDEADBEEF, WAIT_CYCLES=2 -> mem_write high one cycle (3rd WAIT cycle), resp_valid 4 cycles after accept, resp_err=0.
REQ-025 Load addr=1028 after REQ-024 -> mem_read high 3 cycles, resp_rdata=0xDEADBEEF, freeze low in RESP cycle.
REQ-026 Load addr=1020, then 1280, then 1030 -> each resp_err=1 one cycle after accept, no mem strobes, resp_rdata=0.
REQ-027 Boundary: store/load addr=1276 (last word) with WAIT_CYCLES=0 -> accepted, 2-cycle latency, data round-trips.
REQ-028 rst pulsed in 2nd WAIT cycle of store to 1032 -> no mem_write, no resp_valid, later load of 1032 returns prior contents.
REQ-029 Back-to-back req_valid held high with changing req_addr -> req_ready=0 during WAIT/RESP, second request accepted only in the following IDLE cycle.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default geometry for the MEM-stage data-memory access controller.
package mem_ctrl_pkg;

    // Controller sequencing: accept in idle, hold the access in wait, pulse the result in resp.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    // Default data-memory window: 64 words starting at byte address 1024.
    localparam logic [31:0] DefBaseAddr   = 32'd1024;
    localparam int unsigned DefDepthWords = 64;

    // Default number of extra wait cycles per access; must fit the counter (0..15).
    localparam int unsigned DefWaitCycles = 2;

    // Width of the per-access wait counter.
    localparam int unsigned CntW = 4;

    // Size in bytes of a window of 32-bit words.
    function automatic logic [31:0] word_span(input int unsigned depth);
        return 32'(depth * 4);
    endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational legality check for a data-memory byte address: inside the window and
// word-aligned. The range test is done on the offset so BASE_ADDR + span never overflows.
module mem_addr_check
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DefBaseAddr,
    parameter int unsigned DEPTH_WORDS = DefDepthWords
) (
    input  logic [31:0] addr,
    output logic        ok
);

    localparam logic [31:0] Span = word_span(DEPTH_WORDS);

    logic [31:0] offset;

    // Unsigned window test plus 4-byte alignment.
    always_comb begin
        offset = addr - BASE_ADDR;
        ok     = (addr >= BASE_ADDR) && (offset < Span) && (addr[1:0] == 2'b00);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller. Accepts one load/store at a time from the
// pipeline, holds the memory strobes for WAIT_CYCLES+1 cycles, then returns a one-cycle
// response. Illegal addresses are rejected straight to the response state without touching
// memory. Upstream stages are frozen while a request is pending or the access is in flight.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DefBaseAddr,
    parameter int unsigned DEPTH_WORDS = DefDepthWords,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        freeze,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    input  logic [31:0] mem_res
);

    // Counter reload value; WAIT_CYCLES is expected to be 0..15.
    localparam logic [CntW-1:0] WaitInit = CntW'(WAIT_CYCLES);

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic            err_q;

    logic addr_ok;
    logic in_wait;
    logic last_wait;

    mem_addr_check #(
        .BASE_ADDR  (BASE_ADDR),
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_addr_check (
        .addr(req_addr),
        .ok  (addr_ok)
    );

    assign in_wait   = (state_q == StWait);
    assign last_wait = in_wait && (cnt_q == '0);

    // Sequencing FSM: latches the request on acceptance so later req_* changes are ignored,
    // and captures the load result on the edge that leaves the wait state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        if (addr_ok) begin
                            we_q    <= req_we;
                            addr_q  <= req_addr;
                            wdata_q <= req_wdata;
                            cnt_q   <= WaitInit;
                            err_q   <= 1'b0;
                            state_q <= StWait;
                        end else begin
                            // Rejected: nothing latched, no memory traffic.
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= StResp;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        rdata_q <= we_q ? 32'd0 : mem_res;
                        err_q   <= 1'b0;
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    // Drop the response registers so nothing lingers after the pulse.
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    we_q    <= 1'b0;
                    addr_q  <= '0;
                    wdata_q <= '0;
                    cnt_q   <= '0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output decode from the registered state; only freeze and mem_write see live inputs.
    always_comb begin
        req_ready   = (state_q == StIdle);
        resp_valid  = (state_q == StResp);
        resp_err    = resp_valid & err_q;
        resp_rdata  = resp_valid ? rdata_q : 32'd0;
        mem_read    = in_wait & ~we_q;
        // A reset in the final wait cycle must suppress the single write.
        mem_write   = last_wait & we_q & ~rst;
        mem_address = in_wait ? addr_q : 32'd0;
        mem_data    = in_wait ? wdata_q : 32'd0;
        freeze      = (req_ready & req_valid) | in_wait;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench: two controllers (WAIT_CYCLES=2 and 0), each paired with a 64-word
// data-memory responder at base 1024. Expected responses go onto a scoreboard queue when a
// request is driven and are popped when the controller pulses resp_valid.
module tb_mem_access_ctrl;

    localparam logic [31:0] Base = 32'd1024;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          rd;
        int          wr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    logic        rv     [2];
    logic        rwe    [2];
    logic [31:0] raddr  [2];
    logic [31:0] rwdata [2];
    logic        rready [2];
    logic        rsv    [2];
    logic [31:0] rrdata [2];
    logic        rerr   [2];
    logic        frz    [2];
    logic        mrd    [2];
    logic        mwr    [2];
    logic [31:0] maddr  [2];
    logic [31:0] mdata  [2];
    logic [31:0] mres   [2];

    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .BASE_ADDR  (Base),
        .DEPTH_WORDS(64),
        .WAIT_CYCLES(2)
    ) u_dut_w2 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (rv[0]),
        .req_we     (rwe[0]),
        .req_addr   (raddr[0]),
        .req_wdata  (rwdata[0]),
        .req_ready  (rready[0]),
        .resp_valid (rsv[0]),
        .resp_rdata (rrdata[0]),
        .resp_err   (rerr[0]),
        .freeze     (frz[0]),
        .mem_read   (mrd[0]),
        .mem_write  (mwr[0]),
        .mem_address(maddr[0]),
        .mem_data   (mdata[0]),
        .mem_res    (mres[0])
    );

    mem_access_ctrl #(
        .BASE_ADDR  (Base),
        .DEPTH_WORDS(64),
        .WAIT_CYCLES(0)
    ) u_dut_w0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (rv[1]),
        .req_we     (rwe[1]),
        .req_addr   (raddr[1]),
        .req_wdata  (rwdata[1]),
        .req_ready  (rready[1]),
        .resp_valid (rsv[1]),
        .resp_rdata (rrdata[1]),
        .resp_err   (rerr[1]),
        .freeze     (frz[1]),
        .mem_read   (mrd[1]),
        .mem_write  (mwr[1]),
        .mem_address(maddr[1]),
        .mem_data   (mdata[1]),
        .mem_res    (mres[1])
    );

    function automatic logic in_range(input logic [31:0] a);
        return (a >= Base) && (a < Base + 32'd256);
    endfunction

    function automatic logic [5:0] widx(input logic [31:0] a);
        logic [31:0] o;
        o = a - Base;
        return o[7:2];
    endfunction

    // Data-memory responders: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= 32'hC0DE_0000 + 32'(i);
        end else if (mwr[0] && in_range(maddr[0])) begin
            mem_a[widx(maddr[0])] <= mdata[0];
        end
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_b[i] <= 32'hB0B0_0000 + 32'(i);
        end else if (mwr[1] && in_range(maddr[1])) begin
            mem_b[widx(maddr[1])] <= mdata[1];
        end
    end

    always_comb begin
        mres[0] = in_range(maddr[0]) ? mem_a[widx(maddr[0])] : 32'd0;
        mres[1] = in_range(maddr[1]) ? mem_b[widx(maddr[1])] : 32'd0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    // Drive one request starting at a negedge, follow it to its response and compare.
    // With hold set, req_valid stays high and req_* switch to the next request after accept.
    task automatic do_req(input int ln, input int wc, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic xerr, input logic [31:0] xrd,
                          input logic hold, input logic nwe, input logic [31:0] na,
                          input logic [31:0] nd);
        exp_t e;
        exp_t got;
        int   n;
        int   rd;
        int   wr;
        logic seen;
        rv[ln]     = 1'b1;
        rwe[ln]    = we;
        raddr[ln]  = a;
        rwdata[ln] = d;
        #1;
        check1("ready_idle", rready[ln], 1'b1);
        check1("freeze_req", frz[ln], 1'b1);
        e.err   = xerr;
        e.rdata = xrd;
        e.lat   = xerr ? 1 : wc + 2;
        e.rd    = (!xerr && !we) ? wc + 1 : 0;
        e.wr    = (!xerr && we) ? 1 : 0;
        sb.push_back(e);
        @(posedge clk);
        n    = 0;
        rd   = 0;
        wr   = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                if (hold) begin
                    rwe[ln]    = nwe;
                    raddr[ln]  = na;
                    rwdata[ln] = nd;
                end else begin
                    rv[ln]     = 1'b0;
                    rwe[ln]    = ~we;
                    raddr[ln]  = ~a;
                    rwdata[ln] = ~d;
                end
            end
            #1;
            if (mrd[ln]) begin
                rd++;
                check("rd_addr", maddr[ln], a);
            end
            if (mwr[ln]) begin
                wr++;
                check("wr_addr", maddr[ln], a);
                check("wr_data", mdata[ln], d);
            end
            if (rsv[ln]) seen = 1'b1;
            else check1("ready_busy", rready[ln], 1'b0);
        end
        check1("resp_seen", seen, 1'b1);
        got = sb.pop_front();
        if (seen) begin
            check1("resp_err", rerr[ln], got.err);
            check("resp_rdata", rrdata[ln], got.rdata);
            check("latency", n, got.lat);
            check("rd_cycles", rd, got.rd);
            check("wr_cycles", wr, got.wr);
            check1("freeze_resp", frz[ln], 1'b0);
            check1("ready_resp", rready[ln], 1'b0);
        end
        @(negedge clk);
        #1;
        check1("resp_drop", rsv[ln], 1'b0);
        check("rdata_idle", rrdata[ln], 32'd0);
        check1("ready_back", rready[ln], 1'b1);
    endtask

    // Store on the WAIT_CYCLES=2 controller, aborted by reset in wait cycle rst_at.
    task automatic abort_store(input logic [31:0] a, input logic [31:0] d, input int rst_at);
        rv[0]     = 1'b1;
        rwe[0]    = 1'b1;
        raddr[0]  = a;
        rwdata[0] = d;
        @(posedge clk);
        for (int k = 1; k <= rst_at; k++) begin
            @(negedge clk);
            if (k == 1) rv[0] = 1'b0;
            if (k == rst_at) rst = 1'b1;
            #1;
            check1("abort_nowrite", mwr[0], 1'b0);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check1("abort_ready", rready[0], 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            check1("abort_noresp", rsv[0], 1'b0);
            check1("abort_nowr2", mwr[0], 1'b0);
        end
    endtask

    initial begin
        rst      = 1'b1;
        mem_init = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rv[i]     = 1'b0;
            rwe[i]    = 1'b0;
            raddr[i]  = 32'd0;
            rwdata[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        mem_init = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check1("rst_ready", rready[i], 1'b1);
            check1("rst_resp", rsv[i], 1'b0);
            check1("rst_err", rerr[i], 1'b0);
            check("rst_rdata", rrdata[i], 32'd0);
            check1("rst_freeze", frz[i], 1'b0);
            check1("rst_mrd", mrd[i], 1'b0);
            check1("rst_mwr", mwr[i], 1'b0);
            check("rst_maddr", maddr[i], 32'd0);
            check("rst_mdata", mdata[i], 32'd0);
        end
        rst = 1'b0;

        // Store then load of the same word.
        do_req(0, 2, 1'b1, 32'd1028, 32'hDEAD_BEEF, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0);
        do_req(0, 2, 1'b0, 32'd1028, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0);

        // Below window, one past the end, misaligned.
        do_req(0, 2, 1'b0, 32'd1020, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0, 0, 0);
        do_req(0, 2, 1'b0, 32'd1280, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0, 0, 0);
        do_req(0, 2, 1'b0, 32'd1030, 32'h0, 1'b1, 32'd0, 1'b0, 1'b0, 0, 0);

        // Reset mid-store (2nd and final wait cycles) must leave memory untouched.
        do_req(0, 2, 1'b1, 32'd1032, 32'hA5A5_0001, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0);
        abort_store(32'd1032, 32'h1234_5678, 2);
        do_req(0, 2, 1'b0, 32'd1032, 32'h0, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0, 0, 0);
        abort_store(32'd1036, 32'hBADB_AD00, 3);
        do_req(0, 2, 1'b0, 32'd1036, 32'h0, 1'b0, 32'hC0DE_0003, 1'b0, 1'b0, 0, 0);

        // Back-to-back with req_valid held and the address changing after accept.
        do_req(0, 2, 1'b1, 32'd1040, 32'h1111_2222, 1'b0, 32'd0, 1'b1, 1'b0, 32'd1028, 32'h0);
        do_req(0, 2, 1'b0, 32'd1028, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, 0);
        do_req(0, 2, 1'b0, 32'd1040, 32'h0, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 0, 0);

        // Zero-wait controller: last word of the window and a rejected misaligned store.
        do_req(1, 0, 1'b1, 32'd1276, 32'h7654_3210, 1'b0, 32'd0, 1'b0, 1'b0, 0, 0);
        do_req(1, 0, 1'b0, 32'd1276, 32'h0, 1'b0, 32'h7654_3210, 1'b0, 1'b0, 0, 0);
        do_req(1, 0, 1'b1, 32'd1026, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b0, 1'b0, 0, 0);
        do_req(1, 0, 1'b0, 32'd1024, 32'h0, 1'b0, 32'hB0B0_0000, 1'b0, 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

endmodule
